// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Owner encodings are carried through the read tag pipeline so each
// returning datum is steered to the requester that issued the read.
package mem_port_arb_pkg;

    // Owner encoding carried in each read tag
    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_D  = 1'b1;

    // Tag width: {valid, owner}
    localparam int ARB_TAG_W = 2;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    // Which requester holds the port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_sel_e;

    // A strobe with no byte enables is a read and expects data back
    function automatic logic is_read(input logic en, input logic [3:0] we);
        return en & (we == 4'b0000);
    endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Fixed-latency tag pipeline for memory read returns.
// A {valid, owner} tag enters stage 0 every cycle and leaves RD_LAT cycles
// later, lining up with the memory read data. No backpressure.
// Ports:
//   clk, rst_n  - clock, async active-low reset (drops all in-flight tags)
//   push_valid  - a read was issued this cycle
//   push_owner  - owner of that read
//   pop_valid   - a read datum is on the memory data bus now
//   pop_owner   - owner of that datum
module mem_rd_tag_pipe
    import mem_port_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_owner,
    output logic pop_valid,
    output logic pop_owner
);

    logic [RD_LAT-1:0] valid_r;
    logic [RD_LAT-1:0] owner_r;

    // Shift register of tags, cleared on reset so dropped reads never return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {RD_LAT{1'b0}};
            owner_r <= {RD_LAT{1'b0}};
        end else begin
            valid_r[0] <= push_valid;
            owner_r[0] <= push_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                owner_r[i] <= owner_r[i-1];
            end
        end
    end

    assign pop_valid = valid_r[RD_LAT-1];
    assign pop_owner = owner_r[RD_LAT-1];

endmodule

// File: rtl/mem_port_arb.sv
// Arbiter sharing one single-ported synchronous memory between the fetch
// unit (IF) and the word-aligned load/store path (D).
// Grant is combinational in the request cycle; read data is steered back to
// its owner through a RD_LAT-deep tag pipeline.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN (IF starvation guard).
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   if_req/if_addr/if_gnt           - fetch request, address, accept
//   if_rvalid/if_rdata              - fetch read return
//   d_req/d_addr/d_wdata/d_we       - data request (d_we==0 means read)
//   d_lock                          - keep D ownership for the next cycle
//   d_gnt, d_rvalid/d_rdata         - data accept and read return
//   mem_en/mem_addr/mem_wdata/mem_we- memory port
//   mem_rdata                       - memory read data (RD_LAT after strobe)
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    gnt_sel_e sel_s;
    logic     lock_r;
    logic     guard_trip_s;
    logic     pop_valid_s;
    logic     pop_owner_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_r;

    // Count consecutive IF denials, saturating; any grant or idle IF clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
        end else if (if_req && !if_gnt) begin
            if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // The guard never breaks an active lock
    assign guard_trip_s = if_req & (wait_cnt_r == WAIT_MAX) & ~lock_r;
`else
    // No guard in this build: strict D priority. MAX_WAIT is still referenced
    // so the parameter list is identical in both builds.
    assign guard_trip_s = 1'b0 & (MAX_WAIT > 0);
`endif

    // Priority select: lock, guard trip, D, IF. Nothing is granted in reset.
    always_comb begin
        sel_s = GNT_NONE;
        if (!rst_n) begin
            sel_s = GNT_NONE;
        end else if (lock_r) begin
            // D owns the second beat; IF is held off even if D is idle
            sel_s = d_req ? GNT_D : GNT_NONE;
        end else if (guard_trip_s) begin
            sel_s = GNT_IF;
        end else if (d_req) begin
            sel_s = GNT_D;
        end else if (if_req) begin
            sel_s = GNT_IF;
        end else begin
            sel_s = GNT_NONE;
        end
    end

    assign if_gnt = (sel_s == GNT_IF);
    assign d_gnt  = (sel_s == GNT_D);

    // Memory port mux driven from the selected requester
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_we    = 4'b0000;
        case (sel_s)
            GNT_IF: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            GNT_D: begin
                mem_en    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_we    = d_we;
            end
            default: begin
                mem_en    = 1'b0;
                mem_addr  = 32'h0000_0000;
                mem_wdata = 32'h0000_0000;
                mem_we    = 4'b0000;
            end
        endcase
    end

    // Lock covers exactly one following cycle; it cannot re-arm while set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= d_gnt & d_lock & ~lock_r;
        end
    end

    mem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (is_read(mem_en, mem_we)),
        .push_owner (d_gnt ? ARB_OWN_D : ARB_OWN_IF),
        .pop_valid  (pop_valid_s),
        .pop_owner  (pop_owner_s)
    );

    assign if_rvalid = pop_valid_s & (pop_owner_s == ARB_OWN_IF);
    assign d_rvalid  = pop_valid_s & (pop_owner_s == ARB_OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0000_0000;
    assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb. Two instances share all inputs:
// u_dut1 (RD_LAT=1) carries the arbitration/lock/guard steps and
// u_dut3 (RD_LAT=3) carries the reset-during-read step.
module tb_mem_port_arb;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic        d_lock;
    logic [31:0] mem_rdata;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_we1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic [3:0]  mem_we3;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arb #(.RD_LAT(1), .MAX_WAIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_lock(d_lock), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_we(mem_we1), .mem_rdata(mem_rdata)
    );

    mem_port_arb #(.RD_LAT(3), .MAX_WAIT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_lock(d_lock), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_we(mem_we3), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled mid-low-phase
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 4'b0000; d_lock = 1'b0;
    endtask

    initial begin
        clear_inputs();
        mem_rdata = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h20; d_we = 4'b1111;
        @(negedge clk); #1;
        // Reset: everything 0 even with requests pending
        chk("rst_if_gnt", {31'b0, if_gnt1}, 32'd0);
        chk("rst_d_gnt", {31'b0, d_gnt1}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en1}, 32'd0);
        chk("rst_mem_addr", mem_addr1, 32'h0);
        chk("rst_mem_we", {28'b0, mem_we1}, 32'd0);
        chk("rst_rdata", if_rdata1 | d_rdata1, 32'h0);
        chk("rst3_gnt", {30'b0, if_gnt3, d_gnt3}, 32'd0);
        step();
        clear_inputs();
        rst_n = 1'b1;
        step();

        // IF read alone
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("t1_if_gnt", {31'b0, if_gnt1}, 32'd1);
        chk("t1_mem_addr", mem_addr1, 32'h100);
        chk("t1_mem_we", {28'b0, mem_we1}, 32'd0);
        step();
        if_req = 1'b0; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("t1_if_rvalid", {31'b0, if_rvalid1}, 32'd1);
        chk("t1_if_rdata", if_rdata1, 32'hDEAD_BEEF);
        chk("t1_d_rvalid", {31'b0, d_rvalid1}, 32'd0);
        chk("t1_d_rdata", d_rdata1, 32'h0);
        chk("t1_idle_en", {31'b0, mem_en1}, 32'd0);
        step();

        // Both request: D wins, IF next; data returns D then IF
        d_req = 1'b1; d_addr = 32'h200; d_we = 4'b0000;
        if_req = 1'b1; if_addr = 32'h104; #1;
        chk("t2_d_gnt", {31'b0, d_gnt1}, 32'd1);
        chk("t2_if_gnt", {31'b0, if_gnt1}, 32'd0);
        chk("t2_mem_addr", mem_addr1, 32'h200);
        step();
        d_req = 1'b0; mem_rdata = 32'h1111_1111; #1;
        chk("t2_if_gnt2", {31'b0, if_gnt1}, 32'd1);
        chk("t2_mem_addr2", mem_addr1, 32'h104);
        chk("t2_d_rvalid", {31'b0, d_rvalid1}, 32'd1);
        chk("t2_d_rdata", d_rdata1, 32'h1111_1111);
        chk("t2_if_rvalid0", {31'b0, if_rvalid1}, 32'd0);
        step();
        if_req = 1'b0; mem_rdata = 32'h2222_2222; #1;
        chk("t2_if_rvalid", {31'b0, if_rvalid1}, 32'd1);
        chk("t2_if_rdata", if_rdata1, 32'h2222_2222);
        chk("t2_d_rvalid0", {31'b0, d_rvalid1}, 32'd0);
        step();

        // Locked split store with IF requesting throughout
        d_req = 1'b1; d_addr = 32'h300; d_we = 4'b1100; d_wdata = 32'hAABB_0000; d_lock = 1'b1;
        if_req = 1'b1; if_addr = 32'h108; #1;
        chk("t3_d_gnt0", {31'b0, d_gnt1}, 32'd1);
        chk("t3_if_gnt0", {31'b0, if_gnt1}, 32'd0);
        chk("t3_mem_we0", {28'b0, mem_we1}, 32'hC);
        chk("t3_mem_wdata0", mem_wdata1, 32'hAABB_0000);
        step();
        d_addr = 32'h304; d_we = 4'b0011; d_wdata = 32'h0000_CCDD; d_lock = 1'b0; #1;
        chk("t3_if_gnt1", {31'b0, if_gnt1}, 32'd0);
        chk("t3_mem_we1", {28'b0, mem_we1}, 32'h3);
        chk("t3_mem_addr1", mem_addr1, 32'h304);
        chk("t3_no_rvalid1", {30'b0, if_rvalid1, d_rvalid1}, 32'd0);
        step();
        d_req = 1'b0; d_we = 4'b0000; #1;
        chk("t3_if_gnt2", {31'b0, if_gnt1}, 32'd1);
        chk("t3_mem_addr2", mem_addr1, 32'h108);
        chk("t3_no_rvalid2", {30'b0, if_rvalid1, d_rvalid1}, 32'd0);
        step();
        if_req = 1'b0; mem_rdata = 32'h3333_3333; #1;
        chk("t3_if_rvalid3", {31'b0, if_rvalid1}, 32'd1);
        step();

        // Lock held while D goes idle: nobody granted
        d_req = 1'b1; d_addr = 32'h400; d_lock = 1'b1; if_req = 1'b1; if_addr = 32'h10C; #1;
        chk("t4_d_gnt0", {31'b0, d_gnt1}, 32'd1);
        step();
        d_req = 1'b0; d_lock = 1'b0; #1;
        chk("t4_gnt_none", {30'b0, if_gnt1, d_gnt1}, 32'd0);
        chk("t4_mem_en", {31'b0, mem_en1}, 32'd0);
        chk("t4_d_rvalid", {31'b0, d_rvalid1}, 32'd1);
        step();
        #1;
        chk("t4_if_gnt2", {31'b0, if_gnt1}, 32'd1);
        clear_inputs();
        step();

        // Back-to-back lock request does not re-arm
        d_req = 1'b1; d_addr = 32'h500; d_we = 4'b1111; d_lock = 1'b1; if_req = 1'b1; #1;
        step();
        #1;
        chk("t5_d_gnt1", {31'b0, d_gnt1}, 32'd1);
        step();
        d_req = 1'b0; #1;
        chk("t5_if_gnt2", {31'b0, if_gnt1}, 32'd1);
        clear_inputs();
        step();

        // Continuous D vs IF
        d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h600; if_req = 1'b1; if_addr = 32'h110; #1;
        for (int c = 0; c < 10; c++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            chk($sformatf("t6_if_gnt_c%0d", c), {31'b0, if_gnt1}, (c % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t6_d_gnt_c%0d", c), {31'b0, d_gnt1}, (c % 5 == 4) ? 32'd0 : 32'd1);
`else
            chk($sformatf("t6_if_starve_c%0d", c), {31'b0, if_gnt1}, 32'd0);
            chk($sformatf("t6_d_gnt_c%0d", c), {31'b0, d_gnt1}, 32'd1);
`endif
            step();
        end
        clear_inputs();
        step();

`ifdef MEM_ARB_STARVE_GUARD_EN
        // Guard reaches its limit while a lock is active: lock wins, IF next
        d_req = 1'b1; d_we = 4'b1111; if_req = 1'b1; #1;
        step(); step(); step();
        d_lock = 1'b1; #1;
        chk("t7_if_gnt3", {31'b0, if_gnt1}, 32'd0);
        step();
        d_lock = 1'b0; #1;
        chk("t7_if_locked", {31'b0, if_gnt1}, 32'd0);
        chk("t7_d_locked", {31'b0, d_gnt1}, 32'd1);
        step();
        #1;
        chk("t7_if_guard", {31'b0, if_gnt1}, 32'd1);
        chk("t7_d_guard", {31'b0, d_gnt1}, 32'd0);
        clear_inputs();
        step();
`endif

        // RD_LAT=3: reset drops an in-flight read
        mem_rdata = 32'h5A5A_5A5A;
        d_req = 1'b1; d_addr = 32'h700; d_we = 4'b0000; #1;
        chk("t8_d_gnt3", {31'b0, d_gnt3}, 32'd1);
        step();
        d_req = 1'b0; #1;
        step();
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; #1;
        chk("t8_rst_gnt", {30'b0, if_gnt3, d_gnt3}, 32'd0);
        chk("t8_rst_mem_en", {31'b0, mem_en3}, 32'd0);
        chk("t8_rst_rvalid", {30'b0, if_rvalid3, d_rvalid3}, 32'd0);
        chk("t8_rst_rdata", d_rdata3 | if_rdata3, 32'h0);
        step();
        rst_n = 1'b1; clear_inputs(); #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t8_dropped_c%0d", c), {31'b0, d_rvalid3}, 32'd0);
            step();
        end
        d_req = 1'b1; d_addr = 32'h704; #1;
        chk("t8_new_gnt", {31'b0, d_gnt3}, 32'd1);
        step();
        d_req = 1'b0; #1;
        chk("t8_lat1", {31'b0, d_rvalid3}, 32'd0);
        step();
        chk("t8_lat2", {31'b0, d_rvalid3}, 32'd0);
        step();
        chk("t8_lat3", {31'b0, d_rvalid3}, 32'd1);
        chk("t8_lat3_data", d_rdata3, 32'h5A5A_5A5A);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
